// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI definitions for the master and the existing slave.
// FSM encoding, default word width and mode-0 constants.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam bit SPI_MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  function automatic int spi_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: shared timing counter plus SCLK level and edge ticks.
// One counter serves half-periods (CLK_DIV) and the CS gap (CS_GAP*CLK_DIV).
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic tog_i,
  input  logic gap_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int GAP_CYC = CS_GAP * CLK_DIV;
  localparam int CW = $clog2(spi_max(CLK_DIV, GAP_CYC) + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;
  logic          sclk_q, sclk_d;

  // Count one period, tick on its last cycle, flip SCLK on ticks when allowed.
  always_comb begin
    last   = gap_i ? GAP_LAST : HALF_LAST;
    tick_o = en_i && (cnt_q == last);
    cnt_d  = (!en_i || tick_o) ? '0 : cnt_q + CW'(1);
    sclk_d = sclk_q;
    if (tog_i && tick_o) sclk_d = ~sclk_q;
    if (!en_i) sclk_d = SPI_CPOL;
    rise_o = tog_i && tick_o && !sclk_q;
    fall_o = tog_i && tick_o && sclk_q;
  end

  // Counter and SCLK level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 single-word SPI master, MSB first.
// Build option SPI_MASTER_LOOPBACK_EN: sample MOSI instead of the MISO pin.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dataToSend,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] dataReceived,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int N  = DATA_WIDTH;
  localparam int EW = $clog2(2 * N + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * N - 1);

  spi_state_e    state_q, state_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic [N-2:0]  tx_q, tx_d;
  logic [N-1:0]  rx_q, rx_d;
  logic [EW-1:0] edge_q, edge_d;
  logic          done_q, done_d;
  logic [N-1:0]  rdata_q, rdata_d;

  logic tick, rise, fall, sclk;
  logic free, accept, sample;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign sample = mosi_q;
`else
  assign sample = MISO;
`endif

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) u_sclk (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q != ST_IDLE),
    .tog_i ((state_q == ST_SETUP) || (state_q == ST_XFER)),
    .gap_i (state_q == ST_GAP),
    .tick_o(tick),
    .rise_o(rise),
    .fall_o(fall),
    .sclk_o(sclk)
  );

  // The last gap cycle behaves as idle so a waiting start is taken at once.
  assign free   = (state_q == ST_IDLE) || ((state_q == ST_GAP) && tick);
  assign accept = free && start;

  // Next-state and datapath for CS, MOSI and both shift registers.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    edge_d  = edge_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_SETUP, ST_XFER: begin
        if (tick) edge_d = edge_q + EW'(1);
        if (rise) rx_d = {rx_q[N-2:0], sample};
        if (rise && (state_q == ST_SETUP)) state_d = ST_XFER;
        if (fall) begin
          if (edge_q == LAST_EDGE) begin
            state_d = ST_HOLD;
          end else begin
            mosi_d = tx_q[N-2];
            tx_d   = tx_q << 1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          rdata_d = rx_q;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          mosi_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_SETUP;
      cs_d    = 1'b0;
      mosi_d  = dataToSend[N-1];
      tx_d    = dataToSend[N-2:0];
      edge_d  = '0;
    end
  end

  // State and datapath registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      edge_q  <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      edge_q  <= edge_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy         = ~free;
  assign done         = done_q;
  assign dataReceived = rdata_q;
  assign SCLK         = sclk;
  assign CS           = cs_q;
  assign MOSI         = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: spi_master against a timeline model and a mode-0 slave.
// Directed transfers plus randomized starts, data and slave bytes.
module tb_spi_master;

  localparam int N      = 8;
  localparam int D      = 4;
  localparam int G      = 2;
  localparam int T_DONE = 1 + (2 * N + 1) * D;
  localparam int T_END  = T_DONE + G * D - 1;

`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dataToSend = '0;
  logic         busy, done, SCLK, CS, MOSI;
  logic [N-1:0] dataReceived;
  logic         miso = 1'b0;
  logic         miso_pin;

  always #5 clk = ~clk;

  assign miso_pin = LOOP ? 1'b1 : miso;

  spi_master dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dataToSend  (dataToSend),
    .busy        (busy),
    .done        (done),
    .dataReceived(dataReceived),
    .SCLK        (SCLK),
    .CS          (CS),
    .MOSI        (MOSI),
    .MISO        (miso_pin)
  );

  // Behavioural mode-0 slave: loads on CS fall, shifts out on SCLK fall.
  logic [N-1:0] stx = '0;
  logic [N-1:0] scur = '0;
  logic [N-1:0] srx = '0;
  int           sidx = N - 1;
  int           nrise = 0;
  logic         cs_prev = 1'b1;
  logic         sclk_prev = 1'b0;

  always @(CS or SCLK) begin
    if (cs_prev && !CS) begin
      scur  = stx;
      sidx  = N - 1;
      miso  = stx[N-1];
      srx   = '0;
      nrise = 0;
    end else if (!CS && sclk_prev && !SCLK) begin
      if (sidx > 0) sidx = sidx - 1;
      miso = scur[sidx];
    end else if (!CS && !sclk_prev && SCLK) begin
      srx   = {srx[N-2:0], MOSI};
      nrise = nrise + 1;
    end
    cs_prev   = CS;
    sclk_prev = SCLK;
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: t = cycles since the accepted start (0 when idle).
  int           t = 0;
  logic [N-1:0] mtx = '0;
  logic [N-1:0] mstx = '0;
  logic [N-1:0] dr_exp = '0;

  task automatic compare();
    logic ecs, esclk, emosi, ebusy, edone;
    int q, b;
    if (t == 0) begin
      ecs = 1; esclk = 0; emosi = 0; ebusy = 0; edone = 0;
    end else if (t < T_DONE) begin
      q     = (t - 1) / D;
      b     = (q / 2 > N - 1) ? N - 1 : q / 2;
      ecs   = 0;
      esclk = q[0];
      emosi = mtx[N-1-b];
      ebusy = 1;
      edone = 0;
    end else begin
      ecs   = 1;
      esclk = 0;
      emosi = mtx[0];
      ebusy = (t < T_END);
      edone = (t == T_DONE);
    end
    chk("CS", int'(CS), int'(ecs));
    chk("SCLK", int'(SCLK), int'(esclk));
    chk("MOSI", int'(MOSI), int'(emosi));
    chk("busy", int'(busy), int'(ebusy));
    chk("done", int'(done), int'(edone));
    chk("dataReceived", int'(dataReceived), int'(dr_exp));
    if (t == T_DONE) begin
      chk("slave_rx", int'(srx), int'(mtx));
      chk("sclk_rises", nrise, N);
    end
  endtask

  task automatic step();
    bit bsy;
    bsy = (t >= 1) && (t < T_END);
    if (start && !bsy && reset) begin
      t    = 1;
      mtx  = dataToSend;
      mstx = stx;
    end else if (t > 0) begin
      t = (t == T_END) ? 0 : t + 1;
    end
    if (t == T_DONE) dr_exp = LOOP ? mtx : mstx;
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic go_idle();
    for (int i = 0; i < 200 && t != 0; i++) step();
  endtask

  task automatic run_xfer(input logic [N-1:0] d, input logic [N-1:0] s,
                          output int lat, output logic [N-1:0] rx,
                          output logic [N-1:0] sr);
    int c0;
    bit seen;
    go_idle();
    dataToSend = d;
    stx        = s;
    start      = 1'b1;
    c0         = cyc;
    step();
    start = 1'b0;
    seen  = 0;
    lat   = -1;
    rx    = '0;
    sr    = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done) begin
        seen = 1;
        lat  = cyc - c0;
        rx   = dataReceived;
        sr   = srx;
      end else begin
        step();
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, d1c, csf, ndone;
    logic [N-1:0] rx, sr, rx1, sr1, rx2, sr2;
    bit           s1, s2, pcs;

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare();
    end
    reset = 1'b1;
    step();

    // Reset in the middle of a transfer, after the third SCLK rise.
    dataToSend = 8'h96;
    stx        = 8'h69;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && t < 1 + 5 * D + 1; i++) step();
    #2 reset = 1'b0;
    #1;
    chk("rst_CS", int'(CS), 1);
    chk("rst_SCLK", int'(SCLK), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    t      = 0;
    dr_exp = '0;
    step();
    reset = 1'b1;
    step();
    run_xfer(8'h96, 8'h69, lat, rx, sr);
    chk("post_rst_rx", int'(rx), LOOP ? 32'h96 : 32'h69);
    chk("post_rst_slave", int'(sr), 32'h96);

    // Basic transfer: latency and both directions.
    run_xfer(8'b01010011, 8'b00001001, lat, rx, sr);
    chk("latency", lat, 69);
    chk("basic_rx", int'(rx), LOOP ? 32'b01010011 : 32'b00001001);
    chk("basic_slave", int'(sr), 32'b01010011);

    // Back-to-back with start held high.
    go_idle();
    dataToSend = 8'hFF;
    stx        = 8'h00;
    start      = 1'b1;
    step();
    dataToSend = 8'h00;
    stx        = 8'hFF;
    s1 = 0; s2 = 0; d1c = -1; csf = -1; pcs = CS;
    rx1 = '0; sr1 = '0; rx2 = '0; sr2 = '0;
    for (int i = 0; i < 400 && !s2; i++) begin
      step();
      if (done && !s1) begin
        s1 = 1; d1c = cyc; rx1 = dataReceived; sr1 = srx;
      end else if (done && s1) begin
        s2 = 1; rx2 = dataReceived; sr2 = srx;
      end
      if (s1 && csf < 0 && pcs && !CS) begin
        csf   = cyc;
        start = 1'b0;
      end
      pcs = CS;
    end
    chk("b2b_gap", csf - d1c, 8);
    chk("b2b_rx1", int'(rx1), LOOP ? 32'hFF : 32'h00);
    chk("b2b_slave1", int'(sr1), 32'hFF);
    chk("b2b_rx2", int'(rx2), LOOP ? 32'h00 : 32'hFF);
    chk("b2b_slave2", int'(sr2), 32'h00);
    start = 1'b0;

    // Start while busy is ignored; data changes have no effect.
    go_idle();
    dataToSend = 8'h36;
    stx        = 8'h81;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && t < 30; i++) step();
    dataToSend = 8'hAA;
    start      = 1'b1;
    step();
    step();
    start = 1'b0;
    ndone = 0;
    rx = '0; sr = '0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (done) begin
        ndone++;
        rx = dataReceived;
        sr = srx;
      end
    end
    chk("busy_start_dones", ndone, 1);
    chk("busy_start_rx", int'(rx), LOOP ? 32'h36 : 32'h81);
    chk("busy_start_slave", int'(sr), 32'h36);

    // Slave patterns all-zero and mixed.
    run_xfer(8'hC5, 8'b00000000, lat, rx, sr);
    chk("zero_rx", int'(rx), LOOP ? 32'hC5 : 32'h00);
    run_xfer(8'h3A, 8'b11101110, lat, rx, sr);
    chk("mixed_rx", int'(rx), LOOP ? 32'h3A : 32'hEE);

    // Loopback word (MISO tied high in that build).
    run_xfer(8'b10111010, 8'h0F, lat, rx, sr);
    chk("loop_rx", int'(rx), LOOP ? 32'b10111010 : 32'h0F);

    // Randomized starts, data and slave bytes.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 19) == 0);
      dataToSend = N'($urandom);
      stx        = N'($urandom);
      step();
    end
    start = 1'b0;
    go_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
